// File: rtl/control_alu_unit.sv
// ALU operation decoder for the RV32I datapath: maps the operation class plus
// funct3/funct7 to a 4-bit ALU select code, registered with one cycle of latency.
module control_alu_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] modo,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] sel_alu
);

  localparam logic [1:0] MODO_ADD    = 2'b00;
  localparam logic [1:0] MODO_ITYPE  = 2'b01;
  localparam logic [1:0] MODO_RTYPE  = 2'b10;
  localparam logic [1:0] MODO_BRANCH = 2'b11;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;

  logic [3:0] next_sel_s;
  logic [3:0] sel_alu_r;
  logic       unused_funct7_s;

  // Only funct7[5] carries meaning for RV32I ALU ops; the other bits are dropped.
  assign unused_funct7_s = ^{funct7[6], funct7[4:0]};

  // Combinational decode; funct7[5] is referenced only in the branches that need it,
  // so an unknown funct7 cannot leak into any other code.
  always_comb begin
    next_sel_s = ALU_ADD;
    case (modo)
      MODO_ADD: begin
        next_sel_s = ALU_ADD;
      end
      MODO_ITYPE: begin
        case (funct3)
          3'b000:  next_sel_s = ALU_ADD;
          3'b001:  next_sel_s = ALU_SLL;
          3'b010:  next_sel_s = ALU_SLT;
          3'b011:  next_sel_s = ALU_SLTU;
          3'b100:  next_sel_s = ALU_XOR;
          3'b101: begin
            if (funct7[5]) begin
              next_sel_s = ALU_SRA;
            end else begin
              next_sel_s = ALU_SRL;
            end
          end
          3'b110:  next_sel_s = ALU_OR;
          3'b111:  next_sel_s = ALU_AND;
          default: next_sel_s = ALU_ADD;
        endcase
      end
      MODO_RTYPE: begin
        case (funct3)
          3'b000: begin
            if (funct7[5]) begin
              next_sel_s = ALU_SUB;
            end else begin
              next_sel_s = ALU_ADD;
            end
          end
          3'b001:  next_sel_s = ALU_SLL;
          3'b010:  next_sel_s = ALU_SLT;
          3'b011:  next_sel_s = ALU_SLTU;
          3'b100:  next_sel_s = ALU_XOR;
          3'b101: begin
            if (funct7[5]) begin
              next_sel_s = ALU_SRA;
            end else begin
              next_sel_s = ALU_SRL;
            end
          end
          3'b110:  next_sel_s = ALU_OR;
          3'b111:  next_sel_s = ALU_AND;
          default: next_sel_s = ALU_ADD;
        endcase
      end
      MODO_BRANCH: begin
        // Equality branches compare by subtraction; ordered branches use set-less-than.
        case (funct3)
          3'b000:  next_sel_s = ALU_SUB;
          3'b001:  next_sel_s = ALU_SUB;
          3'b100:  next_sel_s = ALU_SLT;
          3'b101:  next_sel_s = ALU_SLT;
          3'b110:  next_sel_s = ALU_SLTU;
          3'b111:  next_sel_s = ALU_SLTU;
          default: next_sel_s = ALU_ADD;
        endcase
      end
      default: begin
        next_sel_s = ALU_ADD;
      end
    endcase
  end

  // Output register; reset forces ADD immediately and drops any pending code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_alu_r <= ALU_ADD;
    end else begin
      sel_alu_r <= next_sel_s;
    end
  end

  assign sel_alu = sel_alu_r;

endmodule

// File: tb/tb_control_alu_unit.sv
// Directed self-checking bench for control_alu_unit: hand-computed select codes,
// one-cycle latency, async reset behaviour and back-to-back streams.
module tb_control_alu_unit;

  logic       clk;
  logic       rst;
  logic [1:0] modo;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [3:0] sel_alu;

  int total;
  int bad;

  control_alu_unit dut (
    .clk     (clk),
    .rst     (rst),
    .modo    (modo),
    .funct3  (funct3),
    .funct7  (funct7),
    .sel_alu (sel_alu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector layout: {modo[1:0], funct3[2:0], funct7[6:0], expected sel[3:0]}
  localparam int NVEC = 27;
  localparam logic [15:0] VECS [NVEC] = '{
    {2'b01, 3'b000, 7'h20, 4'b0000},
    {2'b01, 3'b001, 7'h00, 4'b0010},
    {2'b01, 3'b010, 7'h00, 4'b0011},
    {2'b01, 3'b011, 7'h00, 4'b0100},
    {2'b01, 3'b100, 7'h00, 4'b0101},
    {2'b01, 3'b101, 7'h00, 4'b0110},
    {2'b01, 3'b101, 7'h20, 4'b0111},
    {2'b01, 3'b110, 7'h00, 4'b1000},
    {2'b01, 3'b111, 7'h00, 4'b1001},
    {2'b10, 3'b000, 7'h00, 4'b0000},
    {2'b10, 3'b000, 7'h20, 4'b0001},
    {2'b10, 3'b001, 7'h20, 4'b0010},
    {2'b10, 3'b010, 7'h20, 4'b0011},
    {2'b10, 3'b011, 7'h00, 4'b0100},
    {2'b10, 3'b100, 7'h00, 4'b0101},
    {2'b10, 3'b101, 7'h00, 4'b0110},
    {2'b10, 3'b101, 7'h20, 4'b0111},
    {2'b10, 3'b110, 7'h20, 4'b1000},
    {2'b10, 3'b111, 7'h00, 4'b1001},
    {2'b11, 3'b000, 7'h7f, 4'b0001},
    {2'b11, 3'b001, 7'h20, 4'b0001},
    {2'b11, 3'b010, 7'h20, 4'b0000},
    {2'b11, 3'b011, 7'h00, 4'b0000},
    {2'b11, 3'b100, 7'h7f, 4'b0011},
    {2'b11, 3'b101, 7'h20, 4'b0011},
    {2'b11, 3'b110, 7'h00, 4'b0100},
    {2'b11, 3'b111, 7'h7f, 4'b0100}
  };

  task automatic check_val(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one vector at the falling edge, confirm the old code holds, then check
  // the new code just after the next rising edge.
  task automatic apply_vec(input string tag, input logic [15:0] v, input logic [3:0] prev);
    @(negedge clk);
    modo   = v[15:14];
    funct3 = v[13:11];
    funct7 = v[10:4];
    #1;
    check_val({tag, "_hold"}, sel_alu, prev);
    @(posedge clk);
    #1;
    check_val(tag, sel_alu, v[3:0]);
  endtask

  initial begin
    logic [3:0]  prev;
    logic [15:0] v;
    total  = 0;
    bad    = 0;
    rst    = 1'b1;
    modo   = 2'b10;
    funct3 = 3'b111;
    funct7 = 7'h00;

    // Reset state, held across several edges with a non-ADD decode on the inputs
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_state", sel_alu, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("reset_release_hold", sel_alu, 4'b0000);
    @(posedge clk);
    #1;
    check_val("first_after_reset", sel_alu, 4'b1001);
    prev = 4'b1001;

    // Directed table, forward order (changes every cycle)
    for (int i = 0; i < NVEC; i++) begin
      apply_vec($sformatf("fwd%0d", i), VECS[i], prev);
      prev = VECS[i][3:0];
    end

    // Same table in reverse order for a different back-to-back stream
    for (int i = NVEC - 1; i >= 0; i--) begin
      apply_vec($sformatf("rev%0d", i), VECS[i], prev);
      prev = VECS[i][3:0];
    end

    // Class 00 ignores funct3/funct7; start from a non-ADD code to make it visible
    apply_vec("pre_add", {2'b01, 3'b111, 7'h00, 4'b1001}, prev);
    prev = 4'b1001;
    for (int f = 0; f < 8; f++) begin
      v = {2'b00, 3'(f), 7'h20, 4'b0000};
      apply_vec($sformatf("add_f3_%0d", f), v, prev);
      prev = 4'b0000;
    end

    // Unknown funct7 where it is ignored
    @(negedge clk);
    modo = 2'b11; funct3 = 3'b100; funct7 = 'x;
    @(posedge clk);
    #1;
    check_val("br_blt_f7x", sel_alu, 4'b0011);
    @(negedge clk);
    modo = 2'b01; funct3 = 3'b000; funct7 = 'x;
    @(posedge clk);
    #1;
    check_val("i_add_f7x", sel_alu, 4'b0000);
    funct7 = 7'h00;

    // Asynchronous reset mid-cycle discards the current and the pending code
    apply_vec("pre_rst", {2'b10, 3'b110, 7'h00, 4'b1000}, 4'b0000);
    #2;
    modo = 2'b10; funct3 = 3'b100; funct7 = 7'h00;
    rst = 1'b1;
    #1;
    check_val("async_rst_immediate", sel_alu, 4'b0000);
    @(posedge clk);
    #1;
    check_val("rst_held_over_edge", sel_alu, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("rst_release_hold2", sel_alu, 4'b0000);
    @(posedge clk);
    #1;
    check_val("resume_after_rst", sel_alu, 4'b0101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
